// File: rtl/ln_pipe.sv
// ln_pipe: streaming fixed-point ln/log2 unit (Mitchell log2, scaled by ln2), 3-stage valid/ready pipe
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data (unsigned Q.FRAC_W)/in_mode (0 ln, 1 log2);
//        out_valid/out_ready/out_data (signed Q.FRAC_W)/out_zero (beat came from F==0, out_data saturated)
module ln_pipe #(
  parameter int DATA_W  = 32,
  parameter int FRAC_W  = 10,
  parameter int CONST_W = 16,
  parameter int LN2_Q   = 45426
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_zero
);
  localparam int PW = $clog2(DATA_W);
  localparam int P  = DATA_W + CONST_W;
  logic                     r_v1, r_v2, r_v3;
  logic                     r1_mode, r1_zero, r2_mode, r2_zero, r3_zero;
  logic [DATA_W-1:0]        r1_data;
  logic [PW-1:0]            r1_p;
  logic signed [DATA_W-1:0] r2_l, r3_out;
  logic                     w_adv1, w_adv2, w_adv3, w_zero;
  logic [PW-1:0]            w_p;
  logic [DATA_W-1:0]        w_sh;
  logic [FRAC_W-1:0]        w_mant;
  logic signed [DATA_W-1:0] w_k, w_l, w_ln;
  logic signed [P-1:0]      w_lx, w_prod, w_rnd;
  assign w_adv3    = !r_v3 || out_ready;
  assign w_adv2    = !r_v2 || w_adv3;
  assign w_adv1    = !r_v1 || w_adv2;
  assign in_ready  = w_adv1 && !rst;
  assign out_valid = r_v3;
  assign out_data  = r_v3 ? r3_out : '0;
  assign out_zero  = r_v3 && r3_zero;
  always_comb begin
    w_p    = '0;
    w_zero = in_data == '0;
    for (int i = 0; i < DATA_W; i++)
      if (in_data[i]) w_p = PW'(i);
  end
  // left-align the leading one at the MSB so the mantissa is the next FRAC_W bits
  assign w_sh   = r1_data << (PW'(DATA_W - 1) - r1_p);
  assign w_mant = FRAC_W'(w_sh >> (DATA_W - 1 - FRAC_W));
  assign w_k    = DATA_W'(r1_p) - DATA_W'(FRAC_W);
  assign w_l    = (w_k <<< FRAC_W) + DATA_W'(w_mant);
  assign w_lx   = {{CONST_W{r2_l[DATA_W-1]}}, r2_l};
  assign w_prod = w_lx * P'(LN2_Q);
  assign w_rnd  = w_prod + P'(1 << (CONST_W - 1));
  assign w_ln   = DATA_W'(w_rnd >>> CONST_W);
  always_ff @(posedge clk) begin
    if (rst) begin
      {r_v1, r_v2, r_v3}                             <= '0;
      {r1_mode, r1_zero, r2_mode, r2_zero, r3_zero}  <= '0;
      r1_data                                        <= '0;
      r1_p                                           <= '0;
      r2_l                                           <= '0;
      r3_out                                         <= '0;
    end else begin
      if (w_adv1) begin
        r_v1 <= in_valid;
        if (in_valid) begin
          r1_data <= in_data;
          r1_p    <= w_p;
          r1_zero <= w_zero;
          r1_mode <= in_mode;
        end
      end
      if (w_adv2) begin
        r_v2 <= r_v1;
        if (r_v1) begin
          r2_l    <= w_l;
          r2_zero <= r1_zero;
          r2_mode <= r1_mode;
        end
      end
      if (w_adv3) begin
        r_v3 <= r_v2;
        if (r_v2) begin
          r3_out  <= r2_zero ? {1'b1, {(DATA_W-1){1'b0}}} : r2_mode ? r2_l : w_ln;
          r3_zero <= r2_zero;
        end
      end
    end
  end
endmodule

// File: tb/tb_ln_pipe.sv
// tb_ln_pipe: table vectors, backpressure/reset sequences and random stream against a reference model
module tb_ln_pipe;
  logic        clk = 0, rst = 1, in_valid = 0, in_mode = 0, out_ready = 0;
  logic [31:0] in_data = 0;
  logic        in_ready, out_valid, out_zero;
  logic [31:0] out_data;
  typedef struct { logic [31:0] d; logic z; } exp_t;
  typedef struct { logic [31:0] d; logic m; logic [31:0] eo; logic ez; } vec_t;
  exp_t q[$];
  vec_t tv[12];
  int total = 0, bad = 0, cyc = 0, n_pop = 0, last_pop = 0;
  logic acc;
  always #5 clk = ~clk;
  ln_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_zero(out_zero)
  );
  function automatic logic [32:0] model(input logic [31:0] f, input logic m);
    longint x, p, l, r;
    if (f == 0) return {1'b1, 32'h8000_0000};
    x = longint'(f);
    p = 0;
    while ((x >> (p + 1)) != 0) p++;
    l = (p - 10) * 1024 + ((x - (longint'(1) << p)) * 1024) / (longint'(1) << p);
    r = m ? l : ((l * 45426 + 32768) >>> 16);
    return {1'b0, 32'(r)};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic step(input logic r, input logic v, input logic [31:0] d, input logic m, input logic o);
    exp_t e;
    @(negedge clk);
    rst = r; in_valid = v; in_data = d; in_mode = m; out_ready = o;
    #1;
    cyc++;
    acc = v && in_ready;
    if (acc) begin
      {e.z, e.d} = model(d, m);
      q.push_back(e);
    end
    if (out_valid && o) begin
      chk("sb_empty_on_out", 32'(q.size() == 0), 32'd0);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_data", out_data, e.d);
        chk("sb_zero", 32'(out_zero), 32'(e.z));
      end
      n_pop++;
      last_pop = cyc;
    end
  endtask
  task automatic wait_out(input string nm, input logic [31:0] eo, input logic ez);
    int lat;
    lat = 0;
    do begin
      step(0, 0, 0, 0, 1);
      lat++;
    end while (!out_valid && lat < 8);
    chk({nm, "_lat"}, 32'(lat), 32'd3);
    chk({nm, "_data"}, out_data, eo);
    chk({nm, "_zero"}, 32'(out_zero), 32'(ez));
  endtask
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    logic [31:0] bp[6], hold, d;
    logic        held, md, v;
    int          sent, n0, first;
    tv[0]  = '{32'd1024, 1'b0, 32'd0, 1'b0};
    tv[1]  = '{32'd2048, 1'b0, 32'd710, 1'b0};
    tv[2]  = '{32'd3072, 1'b0, 32'd1065, 1'b0};
    tv[3]  = '{32'd512, 1'b0, -32'sd710, 1'b0};
    tv[4]  = '{32'd3072, 1'b1, 32'd1536, 1'b0};
    tv[5]  = '{32'd512, 1'b1, -32'sd1024, 1'b0};
    tv[6]  = '{32'd1, 1'b1, -32'sd10240, 1'b0};
    tv[7]  = '{32'd0, 1'b0, 32'h8000_0000, 1'b1};
    tv[8]  = '{32'd0, 1'b1, 32'h8000_0000, 1'b1};
    tv[9]  = '{32'd1024, 1'b0, 32'd0, 1'b0};
    tv[10] = '{32'hFFFF_FFFF, 1'b1, 32'd22527, 1'b0};
    tv[11] = '{32'hFFFF_FFFF, 1'b0, 32'd15614, 1'b0};
    repeat (3) step(1, 1, 32'd1024, 0, 1);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    step(0, 0, 0, 0, 1);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    chk("post_rst_out_data", out_data, 32'd0);
    chk("post_rst_out_zero", 32'(out_zero), 32'd0);
    for (int i = 0; i < 12; i++) begin
      step(0, 1, tv[i].d, tv[i].m, 1);
      wait_out($sformatf("vec%0d", i), tv[i].eo, tv[i].ez);
    end
    chk("vec_sb_empty", 32'(q.size()), 32'd0);
    for (int i = 0; i < 6; i++) bp[i] = 32'(1024 * (i + 1) + 37 * i);
    sent = 0;
    held = 0;
    hold = 0;
    for (int k = 0; k < 8; k++) begin
      step(0, sent < 6, bp[sent % 6], 0, 0);
      if (acc) sent++;
      if (out_valid && held) chk("bp_hold_stable", out_data, hold);
      if (out_valid && !held) begin
        hold = out_data;
        held = 1;
      end
    end
    chk("bp_accepted", 32'(sent), 32'd3);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    n0 = n_pop;
    first = -1;
    for (int k = 0; k < 30 && n_pop - n0 < 6; k++) begin
      step(0, sent < 6, bp[sent % 6], 0, 1);
      if (acc) sent++;
      if (n_pop - n0 == 1 && first < 0) first = cyc;
    end
    chk("bp_count", 32'(n_pop - n0), 32'd6);
    chk("bp_back_to_back", 32'(last_pop - first), 32'd5);
    md = 0;
    for (int k = 0; k < 400; k++) begin
      v = $urandom_range(0, 3) != 0;
      d = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 15) == 0) d = 0;
      step(0, v, d, md, 1'($urandom_range(0, 1)));
      if (acc) md = ~md;
    end
    for (int k = 0; k < 20 && q.size() > 0; k++) step(0, 0, 0, 0, 1);
    chk("rand_drain_empty", 32'(q.size()), 32'd0);
    for (int j = 0; j < 3; j++) step(0, 1, 32'(1024 * (j + 2)), 0, 0);
    step(0, 0, 0, 0, 0);
    chk("mid_full_valid", 32'(out_valid), 32'd1);
    step(1, 0, 0, 0, 0);
    q.delete();
    step(0, 0, 0, 0, 1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_data", out_data, 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    n0 = n_pop;
    step(0, 1, 32'd2048, 0, 1);
    wait_out("post_rst_beat", 32'd710, 1'b0);
    repeat (6) step(0, 0, 0, 0, 1);
    chk("post_rst_beats_out", 32'(n_pop - n0), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
